// File: rtl/kv_mem_pkg.sv
// Shared types for the memory arbiter: FSM states and grant encoding.
`include "constants.svh"

package kv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int ADDR_W = $bits(logic [`ADDR]);
  localparam int WORD_W = $bits(logic [`WORD]);

  // Grant / last-grant encoding: 0 = fetch master, 1 = data master.
  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/constants.svh
// Bus widths shared by the memory arbiter and its clients.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
`define ADDR 17:0
`define WORD 35:0
`endif

// File: rtl/mem_arb.sv
// Two-master (fetch / data) arbiter onto a single request/ack memory port.
// One transfer at a time: IDLE picks a winner, CMD issues, WAIT holds for mem_ack, DONE acks the master.
`include "constants.svh"

module mem_arb
  import kv_mem_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [`ADDR] i_addr,
  input  logic         i_read,
  input  logic         i_user,
  output logic [`WORD] i_read_data,
  output logic         i_ack,
  input  logic [`ADDR] d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [`WORD] d_write_data,
  input  logic         d_user,
  output logic [`WORD] d_read_data,
  output logic         d_ack,
  output logic [`ADDR] mem_addr,
  output logic [`WORD] mem_write_data,
  output logic         mem_read,
  output logic         mem_write,
  output logic         mem_user,
  input  logic [`WORD] mem_read_data,
  input  logic         mem_ack
);

  mem_state_e   state_q, state_d;
  logic         gnt_q, gnt_d;
  logic         last_q, last_d;
  logic         is_wr_q, is_wr_d;
  logic [`ADDR] addr_q, addr_d;
  logic [`WORD] wdata_q, wdata_d;
  logic         user_q, user_d;
  logic [`WORD] i_rdata_q, i_rdata_d;
  logic [`WORD] d_rdata_q, d_rdata_d;
  logic         i_req, d_req, win;

  // Returns GNT_DATA when the data master should win this arbitration round.
  function automatic logic pick_grant(input logic f_req, input logic dt_req, input logic last_gnt);
    logic res;
    res = GNT_DATA;
    if (f_req && !dt_req) begin
      res = GNT_FETCH;
    end else if (f_req && dt_req && RR_ENABLE) begin
      res = ~last_gnt;
    end
    return res;
  endfunction

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    user_d    = user_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    win       = pick_grant(i_req, d_req, last_q);
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = win;
          last_d  = win;
          // A data request with both strobes high is treated as a write.
          is_wr_d = (win == GNT_DATA) && d_write;
          addr_d  = (win == GNT_DATA) ? d_addr : i_addr;
          user_d  = (win == GNT_DATA) ? d_user : i_user;
          wdata_d = (win == GNT_DATA) ? d_write_data : '0;
          state_d = CMD;
        end
      end
      CMD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!is_wr_q) begin
            if (gnt_q == GNT_DATA) begin
              d_rdata_d = mem_read_data;
            end else begin
              i_rdata_d = mem_read_data;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_FETCH;
      last_q    <= GNT_FETCH;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      user_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      user_q    <= user_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Command and ack strobes decode straight from state, so reset clears them at once.
  assign mem_read       = (state_q == CMD) && !is_wr_q;
  assign mem_write      = (state_q == CMD) && is_wr_q;
  assign i_ack          = (state_q == DONE) && (gnt_q == GNT_FETCH);
  assign d_ack          = (state_q == DONE) && (gnt_q == GNT_DATA);
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_user       = user_q;
  assign i_read_data    = i_rdata_q;
  assign d_read_data    = d_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: round-robin instance with a wait-state memory model,
// plus a fixed-priority instance on the same master inputs.
module tb_mem_arb;
  import kv_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic              i_read, i_user, d_read, d_write, d_user;
  logic [WORD_W-1:0] d_write_data;

  logic [WORD_W-1:0] i_read_data, d_read_data, mem_write_data, mem_read_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              i_ack, d_ack, mem_read, mem_write, mem_user, mem_ack;

  logic [WORD_W-1:0] fp_i_read_data, fp_d_read_data, fp_mem_write_data, fp_mem_read_data;
  logic [ADDR_W-1:0] fp_mem_addr;
  logic              fp_i_ack, fp_d_ack, fp_mem_read, fp_mem_write, fp_mem_user;
  logic              fp_mem_ack = 1'b0;

  mem_arb #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_addr(i_addr), .i_read(i_read), .i_user(i_user),
    .i_read_data(i_read_data), .i_ack(i_ack),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write),
    .d_write_data(d_write_data), .d_user(d_user),
    .d_read_data(d_read_data), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_user(mem_user),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack)
  );

  mem_arb #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .i_addr(i_addr), .i_read(i_read), .i_user(i_user),
    .i_read_data(fp_i_read_data), .i_ack(fp_i_ack),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write),
    .d_write_data(d_write_data), .d_user(d_user),
    .d_read_data(fp_d_read_data), .d_ack(fp_d_ack),
    .mem_addr(fp_mem_addr), .mem_write_data(fp_mem_write_data),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_user(fp_mem_user),
    .mem_read_data(fp_mem_read_data), .mem_ack(fp_mem_ack)
  );

  // Zero-wait memory for the fixed-priority instance.
  assign fp_mem_read_data = 36'o000000000042;
  always @(posedge clk) fp_mem_ack <= fp_mem_read | fp_mem_write;

  // Memory model for the round-robin instance: 8 words indexed by addr[11:9].
  logic [WORD_W-1:0] mem_arr [0:7];
  logic              loaded = 1'b0;
  int                mem_wait = 0;
  bit                mute = 1'b0;
  logic              tb_ack = 1'b0;
  logic              mdl_ack = 1'b0;
  logic [WORD_W-1:0] mdl_rdata = '0;
  bit                busy = 1'b0;
  int                cnt = 0;
  logic [2:0]        pend_idx = '0;
  int                rd_cnt = 0, wr_cnt = 0;

  assign mem_ack       = mdl_ack | tb_ack;
  assign mem_read_data = mdl_rdata;

  always @(posedge clk) begin
    mdl_ack <= 1'b0;
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (!loaded) begin
      for (int k = 0; k < 8; k++) mem_arr[k] <= '0;
      mem_arr[1] <= 36'o123456701234;
      mem_arr[3] <= 36'o111122223333;
      loaded <= 1'b1;
    end else if ((mem_read || mem_write) && !mute) begin
      if (mem_write) mem_arr[mem_addr[11:9]] <= mem_write_data;
      if (mem_wait == 0) begin
        mdl_ack   <= 1'b1;
        mdl_rdata <= mem_arr[mem_addr[11:9]];
      end else begin
        busy     <= 1'b1;
        cnt      <= mem_wait;
        pend_idx <= mem_addr[11:9];
      end
    end else if (busy) begin
      if (cnt == 1) begin
        mdl_ack   <= 1'b1;
        mdl_rdata <= mem_arr[pend_idx];
        busy      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0o, expected %0o", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_write_data), 64'd0);
    chk({tag, "_mem_rd_wr_user"}, 64'({mem_read, mem_write, mem_user}), 64'd0);
    chk({tag, "_acks"}, 64'({i_ack, d_ack}), 64'd0);
    chk({tag, "_i_rdata"}, 64'(i_read_data), 64'd0);
    chk({tag, "_d_rdata"}, 64'(d_read_data), 64'd0);
  endtask

  // Raise one request, wait (bounded) for its ack, then drop it and idle one cycle.
  task automatic do_xfer(input string tag, input logic dm, input logic wr, input logic rd,
                         input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] wd);
    int   cyc;
    logic stray;
    if (dm) begin
      d_addr = a; d_read = rd; d_write = wr; d_write_data = wd; d_user = 1'b1;
    end else begin
      i_addr = a; i_read = 1'b1; i_user = 1'b0;
    end
    cyc   = 0;
    stray = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      stray = stray | (dm ? i_ack : d_ack);
    end while (!(dm ? d_ack : i_ack) && cyc < 40);
    chk({tag, "_latency"}, 64'(cyc), 64'd3);
    chk({tag, "_other_ack"}, 64'(stray), 64'd0);
    d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   base_rd, base_wr, cyc, n, fp_d, fp_i;
    logic hold_bad, stray;
    logic seq [0:7];

    reset_n = 1'b0;
    i_addr = '0; i_read = 1'b0; i_user = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_user = 1'b0; d_write_data = '0;
    for (int k = 0; k < 8; k++) seq[k] = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Fetch read, zero-wait memory.
    base_rd = rd_cnt;
    do_xfer("t1", 1'b0, 1'b0, 1'b1, 18'o1000, '0);
    chk("t1_i_rdata", 64'(i_read_data), 64'(36'o123456701234));
    chk("t1_rd_pulses", 64'(rd_cnt - base_rd), 64'd1);

    // Data write with 3 memory wait states.
    mem_wait = 3;
    base_wr  = wr_cnt;
    d_addr = 18'o2000; d_write = 1'b1; d_write_data = 36'o777777777777; d_user = 1'b0;
    @(negedge clk);
    chk("t2_cmd_write", 64'(mem_write), 64'd1);
    chk("t2_cmd_addr", 64'(mem_addr), 64'(18'o2000));
    cyc = 0;
    hold_bad = 1'b0;
    while (!mem_ack && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_addr !== 18'o2000 || mem_write_data !== 36'o777777777777) hold_bad = 1'b1;
    end
    chk("t2_wait_cycles", 64'(cyc), 64'd4);
    chk("t2_addr_hold", 64'(hold_bad), 64'd0);
    chk("t2_dack_early", 64'(d_ack), 64'd0);
    @(negedge clk);
    chk("t2_dack", 64'(d_ack), 64'd1);
    d_write = 1'b0;
    @(negedge clk);
    chk("t2_wr_pulses", 64'(wr_cnt - base_wr), 64'd1);
    chk("t2_mem_word", 64'(mem_arr[2]), 64'(36'o777777777777));
    chk("t2_d_rdata", 64'(d_read_data), 64'd0);
    mem_wait = 0;

    // Data read then fetch read: data read register must survive the fetch.
    do_xfer("t3d", 1'b1, 1'b0, 1'b1, 18'o3000, '0);
    chk("t3_d_rdata", 64'(d_read_data), 64'(36'o111122223333));
    do_xfer("t3i", 1'b0, 1'b0, 1'b1, 18'o2000, '0);
    chk("t3_i_rdata", 64'(i_read_data), 64'(36'o777777777777));
    chk("t3_d_rdata_kept", 64'(d_read_data), 64'(36'o111122223333));

    // Read and write strobes together: write wins.
    base_rd = rd_cnt;
    base_wr = wr_cnt;
    do_xfer("t4", 1'b1, 1'b1, 1'b1, 18'o4000, 36'o555555555555);
    chk("t4_wr_pulses", 64'(wr_cnt - base_wr), 64'd1);
    chk("t4_rd_pulses", 64'(rd_cnt - base_rd), 64'd0);
    chk("t4_mem_word", 64'(mem_arr[4]), 64'(36'o555555555555));

    // Both masters request continuously from a fresh reset.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    i_addr = 18'o1000; i_read = 1'b1;
    d_addr = 18'o3000; d_read = 1'b1;
    n = 0; fp_d = 0; fp_i = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (d_ack && n < 8) begin seq[n] = 1'b1; n++; end
      if (i_ack && n < 8) begin seq[n] = 1'b0; n++; end
      if (fp_d_ack) fp_d++;
      if (fp_i_ack) fp_i++;
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rr_grants", 64'(n), 64'd4);
    chk("t5_rr_g0_data", 64'(seq[0]), 64'd1);
    chk("t5_rr_g1_fetch", 64'(seq[1]), 64'd0);
    chk("t5_rr_g2_data", 64'(seq[2]), 64'd1);
    chk("t5_rr_g3_fetch", 64'(seq[3]), 64'd0);
    chk("t5_fp_data_grants", 64'(fp_d), 64'd4);
    chk("t5_fp_fetch_grants", 64'(fp_i), 64'd0);

    // Reset during WAIT, then a stray mem_ack after release.
    mute = 1'b1;
    i_addr = 18'o1000; i_user = 1'b1; i_read = 1'b1;
    @(negedge clk);
    chk("t6_cmd_read", 64'(mem_read), 64'd1);
    @(negedge clk);
    chk("t6_user_wait", 64'(mem_user), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6");
    i_read = 1'b0; i_user = 1'b0;
    @(negedge clk);
    mute = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    tb_ack = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tb_ack = 1'b0;
      stray = stray | i_ack | d_ack;
    end
    chk("t6_late_ack", 64'(stray), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
